// File: rtl/usart_pkg.sv
// rtl/usart_pkg.sv - shared USART constants, receiver state encoding and bit-vote helper
package usart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 140;
    localparam int DATA_BITS            = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/usart_rx_fifo.sv
// rtl/usart_rx_fifo.sv - byte FIFO between the receiver FSM and the consumer stream
module usart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_accept
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_pop;

    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    assign o_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_pop    = i_pop && !o_empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign o_accept = i_push && (!o_full || w_pop);
    assign o_head   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (o_accept) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/usart_rx.sv
// rtl/usart_rx.sv - 8N1 serial receiver with byte FIFO; USART_RX_PARITY_EN adds an even-parity bit
module usart_rx
    import usart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4,
    parameter int LED_HOLD     = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
`ifdef USART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       rx_led
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam int            LW       = $clog2(LED_HOLD + 1);
    localparam logic [CW-1:0] MID_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] MID      = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] MID_P1   = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic [LW-1:0] LED_INIT = LW'(LED_HOLD);

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic                 r_rx_prev;
    rx_state_t            r_state;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_s0;
    logic                 r_s1;
    logic                 r_push;
    logic [DATA_BITS-1:0] r_push_data;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic [LW-1:0]        r_led_cnt;
`ifdef USART_RX_PARITY_EN
    logic                 r_par_bad;
    logic                 r_parity_err;
`endif

    logic w_vote;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic w_accept;

    assign w_vote    = majority3(r_s0, r_s1, r_rx_s);
    assign valid     = !w_empty;
    assign w_pop     = valid && ready;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign rx_led    = (r_led_cnt != '0);
`ifdef USART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    // Only a 1->0 edge starts a frame, so a held break cannot retrigger after a frame error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_s0        <= 1'b1;
            r_s1        <= 1'b1;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_frame_err <= 1'b0;
`ifdef USART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef USART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (r_cnt == MID_M1) r_s0 <= r_rx_s;
            if (r_cnt == MID)    r_s1 <= r_rx_s;

            case (r_state)
                ST_IDLE: begin
                    if (r_rx_prev && !r_rx_s) begin
                        r_cnt   <= '0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_cnt == MID_P1 && w_vote) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == LAST) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == MID_P1) begin
                        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                    end
                    if (r_cnt == LAST) begin
                        r_cnt <= '0;
                        if (r_bit_idx == LAST_BIT) begin
`ifdef USART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef USART_RX_PARITY_EN
                ST_PARITY: begin
                    if (r_cnt == MID_P1) begin
                        r_par_bad <= (^r_shift) ^ w_vote;
                    end
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (r_cnt == MID_P1) begin
                        r_state <= ST_IDLE;
                        if (!w_vote) begin
                            r_frame_err <= 1'b1;
`ifdef USART_RX_PARITY_EN
                        end else if (r_par_bad) begin
                            r_parity_err <= 1'b1;
`endif
                        end else begin
                            r_push      <= 1'b1;
                            r_push_data <= r_shift;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
            r_led_cnt <= '0;
        end else begin
            if (r_push && !w_accept) begin
                r_overrun <= 1'b1;
            end
            if (w_accept) begin
                r_led_cnt <= LED_INIT;
            end else if (r_led_cnt != '0) begin
                r_led_cnt <= r_led_cnt - 1'b1;
            end
        end
    end

    usart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (r_push),
        .i_push_data (r_push_data),
        .i_pop       (w_pop),
        .o_head      (data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_accept    (w_accept)
    );

endmodule

// File: tb/tb_usart_rx.sv
// tb/tb_usart_rx.sv - directed self-checking bench for usart_rx
module tb_usart_rx;

    localparam int CPB = 140;
`ifdef USART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Cycle of the frame (counted from the start-bit edge) on which the stop vote registers the push.
    localparam int STOP_VOTE = (NBITS - 1) * CPB + 4 + CPB / 2 + 1;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       rx_led;
`ifdef USART_RX_PARITY_EN
    logic       parity_err;
`endif

    usart_rx dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
`ifdef USART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .rx_led     (rx_led)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] rx_q[$];
    int   fe_pulses    = 0;
    int   fe_cycles    = 0;
    int   pe_pulses    = 0;
    int   valid_cycles = 0;
    logic fe_d         = 1'b0;
    logic pe_d         = 1'b0;

    always @(negedge clk) begin
        if (valid && ready) rx_q.push_back(data);
        if (valid) valid_cycles <= valid_cycles + 1;
        if (frame_err) fe_cycles <= fe_cycles + 1;
        if (frame_err && !fe_d) fe_pulses <= fe_pulses + 1;
        fe_d <= frame_err;
`ifdef USART_RX_PARITY_EN
        if (parity_err && !pe_d) pe_pulses <= pe_pulses + 1;
        pe_d <= parity_err;
`endif
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_v, input int pop_at);
        logic [10:0] fr;
        fr      = '1;
        fr[0]   = 1'b0;
        fr[8:1] = b;
`ifdef USART_RX_PARITY_EN
        fr[9]   = par_v;
        fr[10]  = stop_v;
`else
        fr[9]   = stop_v;
`endif
        for (int i = 0; i < NBITS; i++) begin
            for (int c = 0; c < CPB; c++) begin
                @(posedge clk);
                #1;
                if (c == 0) rx = fr[i];
                if (pop_at >= 0 && (i * CPB + c) == pop_at)     ready = 1'b1;
                if (pop_at >= 0 && (i * CPB + c) == pop_at + 1) ready = 1'b0;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1, ^b, -1);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    int base;
    int fe0;
    int fc0;
    int vc0;
    int pe0;
    logic [7:0] exp5 [5];

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_led", rx_led, 1'b0);
        #1 reset = 1'b0;

        // Single byte with consumer always ready
        ready = 1'b1;
        idle_bits(1);
        base = rx_q.size();
        vc0  = valid_cycles;
        fe0  = fe_pulses;
        send_byte(8'hA5);
        idle_bits(1);
        check("a5_count", rx_q.size() - base, 1);
        check("a5_data", rx_q[base], 8'hA5);
        check("a5_valid_cycles", valid_cycles - vc0, 1);
        check("a5_no_fe", fe_pulses - fe0, 0);
        check("a5_led", rx_led, 1'b1);

        // Short low glitch on an idle line
        base = rx_q.size();
        rx = 1'b0;
        repeat (40) @(posedge clk);
        #1 rx = 1'b1;
        idle_bits(2);
        check("glitch_count", rx_q.size() - base, 0);
        check("glitch_valid", valid, 1'b0);
        check("glitch_no_fe", fe_pulses - fe0, 0);

        // Stop bit low, line held low as a break, then a good byte
        base = rx_q.size();
        fe0  = fe_pulses;
        fc0  = fe_cycles;
        send_frame(8'h3C, 1'b0, ^8'h3C, -1);
        repeat (20 * CPB) @(posedge clk);
        #1;
        check("fe_pulses", fe_pulses - fe0, 1);
        check("fe_width", fe_cycles - fc0, 1);
        check("fe_no_data", rx_q.size() - base, 0);
        idle_bits(2);
        send_byte(8'h55);
        idle_bits(1);
        check("break_single_fe", fe_pulses - fe0, 1);
        check("break_55_count", rx_q.size() - base, 1);
        check("break_55_data", rx_q[base], 8'h55);

        // Overrun with the consumer stalled
        reset_dut();
        ready = 1'b0;
        base  = rx_q.size();
        for (int b = 1; b <= 5; b++) begin
            send_byte(8'(b));
            idle_bits(1);
            if (b == 4) check("ovr_not_yet", overrun, 1'b0);
        end
        check("ovr_set", overrun, 1'b1);
        check("ovr_valid", valid, 1'b1);
        check("ovr_head", data, 8'h01);
        ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("ovr_drain_count", rx_q.size() - base, 4);
        for (int k = 0; k < 4; k++) check("ovr_drain_data", rx_q[base + k], 8'(k + 1));
        check("ovr_empty", valid, 1'b0);
        check("ovr_sticky", overrun, 1'b1);

        // Full FIFO popped in the same cycle the fifth byte is pushed
        reset_dut();
        ready = 1'b0;
        base  = rx_q.size();
        exp5[0] = 8'h11; exp5[1] = 8'h22; exp5[2] = 8'h33; exp5[3] = 8'h44; exp5[4] = 8'h5A;
        for (int k = 0; k < 4; k++) begin
            send_byte(exp5[k]);
            idle_bits(1);
        end
        send_frame(exp5[4], 1'b1, ^exp5[4], STOP_VOTE);
        idle_bits(1);
        check("pp_no_overrun", overrun, 1'b0);
        check("pp_popped_one", rx_q.size() - base, 1);
        ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("pp_count", rx_q.size() - base, 5);
        for (int k = 0; k < 5; k++) check("pp_order", rx_q[base + k], exp5[k]);

        // Reset in the middle of a frame, then a clean byte
        ready = 1'b1;
        base  = rx_q.size();
        fe0   = fe_pulses;
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1 rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        reset_dut();
        check("mid_rst_valid", valid, 1'b0);
        idle_bits(2);
        send_byte(8'h81);
        idle_bits(1);
        check("mid_rst_count", rx_q.size() - base, 1);
        check("mid_rst_data", rx_q[base], 8'h81);
        check("mid_rst_no_fe", fe_pulses - fe0, 0);

`ifdef USART_RX_PARITY_EN
        base = rx_q.size();
        pe0  = pe_pulses;
        send_frame(8'h81, 1'b1, 1'b1, -1);
        idle_bits(1);
        check("par_err_pulse", pe_pulses - pe0, 1);
        check("par_no_data", rx_q.size() - base, 0);
`else
        pe0 = pe_pulses;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
